// File: rtl/fifo_word_unpacker.sv
// fifo_word_unpacker
// Pops wide entries from the transmit FIFO and streams them out as
// DW_OUT-bit 1553 data words, least-significant slice first, for exactly
// word_count words per message (word_count==0 means 2**WC_W words).
// busy/done frame the message; out_last marks its final word.

module fifo_word_unpacker #(
   parameter int DW_IN  = 32,
   parameter int DW_OUT = 16,
   parameter int WC_W   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [WC_W-1:0]   word_count,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              fifo_r_req,
   input  logic [DW_IN-1:0]  fifo_data,
   input  logic              fifo_empty,
   output logic              out_valid,
   output logic [DW_OUT-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready
);

   localparam int R  = DW_IN / DW_OUT;
   localparam int SW = (R > 1) ? $clog2(R) : 1;

   localparam logic [SW-1:0] LAST_SLICE = SW'(R - 1);
   localparam logic [SW-1:0] SLICE_ONE  = SW'(1);
   localparam logic [WC_W:0] ONE_WORD   = (WC_W + 1)'(1);
   localparam logic [WC_W:0] MAX_WORDS  = {1'b1, {WC_W{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_EMIT,
      S_DONE
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [WC_W:0]     remaining;
   logic [SW-1:0]     slice;
   logic [DW_IN-1:0]  word_buf;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and output decode; abort overrides everything outside IDLE.
   // NOTE: every output is given a default first so no path leaves a
   // variable unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      fifo_r_req = 1'b0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      out_data   = '0;

      case (state)
         S_IDLE: begin
            if (start && !abort) state_next = S_FETCH;
         end

         S_FETCH: begin
            busy       = 1'b1;
            fifo_r_req = !fifo_empty && !abort;
            if (abort)           state_next = S_IDLE;
            else if (fifo_r_req) state_next = S_WAIT;
         end

         S_WAIT: begin
            busy       = 1'b1;
            state_next = abort ? S_IDLE : S_EMIT;
         end

         S_EMIT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = word_buf[int'(slice) * DW_OUT +: DW_OUT];
            out_last  = (remaining == ONE_WORD);
            if (abort) begin
               state_next = S_IDLE;
            end else if (out_ready) begin
               if (remaining == ONE_WORD)   state_next = S_DONE;
               else if (slice == LAST_SLICE) state_next = S_FETCH;
            end
         end

         S_DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = S_IDLE;
         end

         default: state_next = S_IDLE;
      endcase
   end

   // Datapath: word counter, slice pointer and the captured FIFO entry.
   // NOTE: word_buf is a single register, not a memory, so it is reset
   // along with the counters and out_data reads 0 straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining <= '0;
         slice     <= '0;
         word_buf  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && !abort) begin
                  remaining <= (word_count == '0) ? MAX_WORDS : {1'b0, word_count};
                  slice     <= '0;
               end
            end

            S_WAIT: begin
               if (!abort) begin
                  word_buf <= fifo_data;
                  slice    <= '0;
               end
            end

            S_EMIT: begin
               if (out_ready && !abort) begin
                  remaining <= remaining - ONE_WORD;
                  if (remaining != ONE_WORD && slice != LAST_SLICE)
                     slice <= slice + SLICE_ONE;
               end
            end

            default: ;
         endcase
      end
   end

endmodule
